// File: rtl/nn_bench_pkg.sv
// nn_bench_pkg: shared state encoding, word type and default sizing for the inference bench harness.
package nn_bench_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NFRAC = 10;
  localparam int DEF_INPUT_SIZE = 16;
  localparam int DEF_OUTPUT_SIZE = 5;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TIMEOUT = 4095;
  typedef enum logic [1:0] {LOAD, FULL, RUN, DONE} state_t;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_FULL = FULL;
  localparam logic [1:0] ST_RUN = RUN;
  localparam logic [1:0] ST_DONE = DONE;
  typedef logic signed [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/nn_bench_harness_if.sv
// nn_bench_harness_if: host load/control/readback bus plus the parallel core handshake.
interface nn_bench_harness_if import nn_bench_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int IDX_W = $clog2(OUTPUT_SIZE + 1);
  logic load_valid;
  logic signed [WIDTH-1:0] load_data;
  logic load_ready;
  logic start;
  logic clear;
  logic busy;
  logic done;
  logic timeout_err;
  logic [CNT_W-1:0] latency;
  logic [IDX_W-1:0] rd_idx;
  logic signed [WIDTH-1:0] rd_data;
  logic dut_input_ready;
  logic signed [WIDTH-1:0] dut_input_data [INPUT_SIZE];
  logic dut_output_ready;
  logic signed [WIDTH-1:0] dut_output_data [OUTPUT_SIZE];
  modport slave (
    input load_valid, load_data, start, clear, rd_idx, dut_output_ready, dut_output_data,
    output load_ready, busy, done, timeout_err, latency, rd_data, dut_input_ready, dut_input_data
  );
  modport master (
    output load_valid, load_data, start, clear, rd_idx, dut_output_ready, dut_output_data,
    input load_ready, busy, done, timeout_err, latency, rd_data, dut_input_ready, dut_input_data
  );
endinterface

// File: rtl/bench_latency_counter.sv
// bench_latency_counter: run-cycle counter with clear, enable and timeout compare.
module bench_latency_counter import nn_bench_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_timeout_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign hit_timeout_o = cnt_q == CNT_W'(TIMEOUT);
endmodule

// File: rtl/nn_bench_harness.sv
// nn_bench_harness: serial-load, launch, time and capture one pass of a fully-parallel inference core.
// Results are read back one word at a time through rd_idx so the top needs no wide I/O.
module nn_bench_harness import nn_bench_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NFRAC = DEF_NFRAC,
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               reset,
  nn_bench_harness_if.slave bus
);
  localparam int PTR_W = INPUT_SIZE > 1 ? $clog2(INPUT_SIZE) : 1;
  localparam int IDX_W = $clog2(OUTPUT_SIZE + 1);
  if (NFRAC >= WIDTH || $clog2(TIMEOUT + 1) > CNT_W) begin : g_bad_cfg
    $error("nn_bench_harness: NFRAC must be below WIDTH and TIMEOUT must fit in CNT_W");
  end
  logic [1:0] state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic signed [WIDTH-1:0] in_buf_q [INPUT_SIZE];
  logic signed [WIDTH-1:0] in_buf_d [INPUT_SIZE];
  logic signed [WIDTH-1:0] out_buf_q [OUTPUT_SIZE];
  logic signed [WIDTH-1:0] out_buf_d [OUTPUT_SIZE];
  logic [CNT_W-1:0] latency_q, latency_d;
  logic terr_q, terr_d;
  logic [CNT_W-1:0] cnt;
  logic hit_timeout;
  logic beat, last_beat, launch, capture, expire;
  // clear outranks every other event, so each qualifier is gated by it here once
  assign beat = !bus.clear && state_q == ST_LOAD && bus.load_valid;
  assign last_beat = beat && wr_ptr_q == PTR_W'(INPUT_SIZE - 1);
  assign launch = !bus.clear && bus.start && (state_q == ST_FULL || state_q == ST_DONE);
  assign capture = !bus.clear && state_q == ST_RUN && bus.dut_output_ready;
  assign expire = !bus.clear && state_q == ST_RUN && !bus.dut_output_ready && hit_timeout;
  bench_latency_counter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr_i(launch),
    .en_i(state_q == ST_RUN),
    .cnt_o(cnt),
    .hit_timeout_o(hit_timeout)
  );
  always_comb begin
    state_d = bus.clear ? ST_LOAD : last_beat ? ST_FULL : launch ? ST_RUN :
              (capture || expire) ? ST_DONE : state_q;
    wr_ptr_d = (bus.clear || last_beat) ? '0 : beat ? wr_ptr_q + 1'b1 : wr_ptr_q;
    in_buf_d = in_buf_q;
    for (int i = 0; i < INPUT_SIZE; i++)
      if (beat && wr_ptr_q == PTR_W'(i)) in_buf_d[i] = bus.load_data;
    out_buf_d = out_buf_q;
    if (capture) out_buf_d = bus.dut_output_data;
    latency_d = capture ? cnt : expire ? CNT_W'(TIMEOUT) : latency_q;
    terr_d = launch ? 1'b0 : expire ? 1'b1 : terr_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_LOAD;
      wr_ptr_q <= '0;
      in_buf_q <= '{default: '0};
      out_buf_q <= '{default: '0};
      latency_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      in_buf_q <= in_buf_d;
      out_buf_q <= out_buf_d;
      latency_q <= latency_d;
      terr_q <= terr_d;
    end
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < OUTPUT_SIZE; i++)
      if (bus.rd_idx == IDX_W'(i)) bus.rd_data = out_buf_q[i];
  end
  // cnt is zero only in the first RUN cycle because launch clears it and it never wraps
  assign bus.dut_input_ready = state_q == ST_RUN && cnt == '0;
  assign bus.dut_input_data = in_buf_q;
  assign bus.load_ready = state_q == ST_LOAD;
  assign bus.busy = state_q == ST_RUN;
  assign bus.done = state_q == ST_DONE;
  assign bus.timeout_err = terr_q;
  assign bus.latency = latency_q;
endmodule

// File: tb/tb_nn_bench_harness.sv
// tb_nn_bench_harness: directed stimulus with a phase-level expectation model checked every cycle.
module tb_nn_bench_harness;
  import nn_bench_pkg::*;
  localparam int IN = 16;
  localparam int OUT = 5;
  localparam int TMO = 20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  nn_bench_harness_if #(.WIDTH(16), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .CNT_W(16)) bus ();
  nn_bench_harness #(
    .WIDTH(16), .NFRAC(10), .INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .CNT_W(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  typedef enum {P_LOAD, P_FULL, P_RUN, P_DONE} phase_t;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int runcyc = 0;
  phase_t m_phase;
  int m_ptr;
  word_t m_in [IN];
  word_t m_out [OUT];
  int m_lat;
  bit m_terr;
  bit m_pulse;
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    m_phase = P_LOAD;
    m_ptr = 0;
    m_in = '{default: 0};
    m_out = '{default: 0};
    m_lat = 0;
    m_terr = 0;
    m_pulse = 0;
  endtask
  always @(negedge clk) begin
    int idx;
    check("load_ready", longint'(bus.load_ready), longint'(m_phase == P_LOAD));
    check("busy", longint'(bus.busy), longint'(m_phase == P_RUN));
    check("done", longint'(bus.done), longint'(m_phase == P_DONE));
    check("timeout_err", longint'(bus.timeout_err), longint'(m_terr));
    check("latency", longint'(bus.latency), longint'(m_lat));
    check("input_ready", longint'(bus.dut_input_ready), longint'(m_pulse));
    for (int i = 0; i < IN; i++)
      check("input_data", longint'(bus.dut_input_data[i]), longint'(m_in[i]));
    idx = int'(bus.rd_idx);
    check("rd_data", longint'(bus.rd_data), idx < OUT ? longint'(m_out[idx]) : 64'sd0);
    if (bus.dut_input_ready) pulses++;
    if (bus.busy) runcyc++;
  end
  task automatic load(input int n, input int base);
    bus.load_valid = 1'b1;
    for (int j = 0; j < n; j++) begin
      bus.load_data = word_t'(base + j);
      step();
      m_in[m_ptr] = word_t'(base + j);
      m_ptr++;
      if (m_ptr == IN) begin
        m_ptr = 0;
        m_phase = P_FULL;
      end
    end
    bus.load_valid = 1'b0;
  endtask
  // resp < 0 means the core never answers; otherwise it answers resp cycles after the pulse
  task automatic do_run(input int resp, input int base);
    word_t d [OUT];
    for (int k = 0; k < OUT; k++) d[k] = word_t'(base * (k + 1));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_phase = P_RUN;
    m_pulse = 1;
    m_terr = 0;
    for (int k = 0; k <= TMO; k++) begin
      if (k == resp) begin
        bus.dut_output_ready = 1'b1;
        for (int j = 0; j < OUT; j++) bus.dut_output_data[j] = d[j];
      end
      step();
      bus.dut_output_ready = 1'b0;
      m_pulse = 0;
      if (k == resp) begin
        m_phase = P_DONE;
        m_lat = k;
        m_out = d;
        break;
      end
      if (k == TMO) begin
        m_phase = P_DONE;
        m_lat = TMO;
        m_terr = 1;
      end
    end
  endtask
  initial begin
    int p0, r0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.rd_idx = 3'd2;
    bus.dut_output_ready = 1'b0;
    bus.dut_output_data = '{default: 0};
    model_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("rst_load_ready", longint'(bus.load_ready), 1);
    check("rst_done", longint'(bus.done), 0);
    load(15, 1);
    bus.load_valid = 1'b1;
    bus.load_data = 16'sd16;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_in[15] = 16'sd16;
    m_ptr = 0;
    m_phase = P_FULL;
    bus.load_data = 16'sd99;
    step();
    bus.load_valid = 1'b0;
    check("load_ready_drop", longint'(bus.load_ready), 0);
    for (int i = 0; i < IN; i++) check("in_vec", longint'(bus.dut_input_data[i]), longint'(i + 1));
    p0 = pulses;
    do_run(7, 10);
    check("lat7", longint'(bus.latency), 7);
    check("done7", longint'(bus.done), 1);
    check("pulse_once", longint'(pulses - p0), 1);
    bus.rd_idx = 3'd2;
    #1 check("rd2", longint'(bus.rd_data), 30);
    bus.rd_idx = 3'd5;
    #1 check("rd5", longint'(bus.rd_data), 0);
    bus.rd_idx = 3'd4;
    #1 check("rd4", longint'(bus.rd_data), 50);
    bus.rd_idx = 3'd7;
    #1 check("rd7", longint'(bus.rd_data), 0);
    bus.rd_idx = 3'd2;
    bus.dut_output_ready = 1'b1;
    bus.dut_output_data = '{default: 77};
    step();
    bus.dut_output_ready = 1'b0;
    check("stray_ignored", longint'(bus.rd_data), 30);
    r0 = runcyc;
    do_run(-1, 0);
    check("tmo_runcyc", longint'(runcyc - r0), 21);
    check("tmo_lat", longint'(bus.latency), 20);
    check("tmo_err", longint'(bus.timeout_err), 1);
    check("tmo_keep_out", longint'(bus.rd_data), 30);
    do_run(TMO, -1);
    check("tie_err", longint'(bus.timeout_err), 0);
    check("tie_lat", longint'(bus.latency), 20);
    check("tie_rd2", longint'(bus.rd_data), -3);
    p0 = pulses;
    do_run(3, 3);
    check("rep_lat3", longint'(bus.latency), 3);
    do_run(5, 5);
    check("rep_lat5", longint'(bus.latency), 5);
    check("rep_pulses", longint'(pulses - p0), 2);
    check("rep_in_keep", longint'(bus.dut_input_data[9]), 10);
    do_run(0, 7);
    check("lat0", longint'(bus.latency), 0);
    check("lat0_rd2", longint'(bus.rd_data), 21);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_phase = P_RUN;
    m_pulse = 1;
    step();
    m_pulse = 0;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    m_phase = P_LOAD;
    m_ptr = 0;
    check("clr_run_load", longint'(bus.load_ready), 1);
    load(5, 100);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    m_ptr = 0;
    load(16, 200);
    check("clr_reload_full", longint'(bus.load_ready), 0);
    check("clr_in0", longint'(bus.dut_input_data[0]), 200);
    check("clr_in15", longint'(bus.dut_input_data[15]), 215);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_phase = P_RUN;
    m_pulse = 1;
    step();
    m_pulse = 0;
    step();
    reset = 1'b1;
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    bus.dut_output_ready = 1'b1;
    bus.dut_output_data = '{default: 55};
    step();
    bus.dut_output_ready = 1'b0;
    check("late_rd", longint'(bus.rd_data), 0);
    check("late_done", longint'(bus.done), 0);
    load(16, 300);
    check("post_rst_full", longint'(bus.load_ready), 0);
    check("post_rst_in3", longint'(bus.dut_input_data[3]), 303);
    do_run(2, 1);
    check("post_rst_lat", longint'(bus.latency), 2);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nn_bench_harness.md
# nn_bench_harness

Parametrised benchmark harness that sits between a narrow host/test interface and a fully-parallel fixed-point inference core (batchnorm/dense jet-tagging network or similar).
- Serially loads one input vector, launches the core with a single-cycle `input_ready` pulse, and captures its parallel output vector.
- Measures core latency in clock cycles, with timeout detection.
- Exposes results through an indexed read port, so the top level needs no wide I/O.

## Interface
Parameters:
- `WIDTH`, 16: fixed-point word width (signed).
- `NFRAC`, 10: fractional bits. Pass-through only; no arithmetic in this block.
- `INPUT_SIZE`, 16: core input channel count, ≥1.
- `OUTPUT_SIZE`, 5: core output channel count, ≥1.
- `CNT_W`, 16: latency counter width.
- `TIMEOUT`, 4095: cycles in RUN before abort, < 2^CNT_W.

Ports (one clock; `reset` is asynchronous, active-high):
- `clk`  in  1  core clock (already buffered).
- `reset`  in  1  async active-high reset.
- `load_valid`  in  1  input word valid.
- `load_data`  in  WIDTH  signed input word.
- `load_ready`  out  1  harness accepts a word.
- `start`  in  1  launch request.
- `clear`  in  1  abort/rearm; returns to LOAD.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `timeout_err`  out  1  last run timed out.
- `latency`  out  CNT_W  last measured latency.
- `rd_idx`  in  $clog2(OUTPUT_SIZE+1)  output channel select.
- `rd_data`  out  WIDTH  captured output word.
- `dut_input_ready`  out  1  launch pulse to the core.
- `dut_input_data`  out  WIDTH×INPUT_SIZE (unpacked signed array)  held input vector.
- `dut_output_ready`  in  1  core result valid.
- `dut_output_data`  in  WIDTH×OUTPUT_SIZE (unpacked signed array)  core result.

## Operation
States:
- **LOAD**: `load_ready`=1. Each cycle with `load_valid`&&`load_ready`:
  - Write `in_buf[wr_ptr]` and increment `wr_ptr`.
  - The write at `wr_ptr`==INPUT_SIZE-1 moves to FULL and clears `wr_ptr`.
  - `start` is ignored in LOAD.
- **FULL**: `load_ready`=0. On `start`:
  - Go to RUN.
  - Clear `cnt` to 0.
  - Clear `timeout_err`.
- **RUN**: `busy`=1.
  - `dut_input_ready`=1 only in the first RUN cycle.
  - `cnt` increments every RUN cycle after the first.
  - On `dut_output_ready`: `out_buf` <= `dut_output_data`, `latency` <= `cnt`, go to DONE.
  - Else if `cnt`==TIMEOUT: `latency` <= TIMEOUT, `timeout_err` <= 1, `out_buf` unchanged, go to DONE.
  - If both happen in the same cycle, the output capture wins and `timeout_err` stays 0.
- **DONE**: `done`=1.
  - `start` relaunches the same `in_buf` (go to RUN, same rules as FULL), which supports repeat runs without reloading.
  - `dut_output_ready` outside RUN is ignored.
- `clear` takes priority in every state: go to LOAD, `wr_ptr`=0. `in_buf`, `out_buf`, `latency` and `timeout_err` are retained.
- `dut_input_data` = `in_buf`, continuously, stable from FULL through DONE.
- `rd_data` = `out_buf[rd_idx]`, combinational; 0 when `rd_idx` ≥ OUTPUT_SIZE.

## Timing
- Reset values: state LOAD, `load_ready` 1, all other outputs 0, `in_buf`/`out_buf`/`cnt`/`wr_ptr` 0.
- Reset mid-RUN aborts immediately. A late `dut_output_ready` after reset is ignored.
- Load phase takes INPUT_SIZE accepted beats. Back-to-back beats are allowed, giving one word per cycle.
- `start` sampled in FULL at edge t: `dut_input_ready` is high in cycle t+1, with `cnt`=0 in that cycle.
- Latency equals the `cnt` value in the cycle where `dut_output_ready`=1. An output in the pulse cycle reports 0.
- `done` rises the cycle after capture. `latency` and `out_buf` are valid in the same cycle `done` rises.
- Timeout path: DONE is entered TIMEOUT+1 cycles after entering RUN.

## Structure
- Package `nn_bench_pkg`:
  - `state_t` enum {LOAD, FULL, RUN, DONE}.
  - `word_t` = logic signed [WIDTH-1:0] typedef (default WIDTH).
  - Default sizing constants.
- Sub-module `bench_latency_counter`: owns `cnt` with clear, enable, and TIMEOUT compare. It outputs `cnt` and `hit_timeout`.
- FSM, input/output buffers and read mux stay in `nn_bench_harness`. No arithmetic on data.

## Test plan
- Reset, then load words 1..16 back-to-back with `load_valid`=1 -> `load_ready` drops after the 16th beat; `dut_input_data[i]`=i+1.
- `start` in FULL; core model asserts `dut_output_ready` 7 cycles after the pulse with outputs {10,20,30,40,50} -> `latency`=7, `done`=1, `rd_data`=30 at `rd_idx`=2, `rd_data`=0 at `rd_idx`=5.
- Core never responds, TIMEOUT=20 -> `done` after 21 RUN cycles, `timeout_err`=1, `latency`=20, `out_buf` unchanged.
- `dut_output_ready` in the same cycle `cnt`==TIMEOUT -> capture taken, `timeout_err`=0, `latency`=TIMEOUT.
- `start` in DONE twice with core latency 3 then 5 -> one `dut_input_ready` pulse per run, `latency` 3 then 5, `in_buf` unchanged.
- Assert `reset` mid-RUN, and separately `clear` mid-LOAD after 5 beats -> state LOAD, `wr_ptr`=0; reset also zeroes all outputs; the next full load is accepted normally.
